cordic_result_serializer: RTL
=============================

Name: cordic_result_serializer

Overview:
- Sits directly downstream of the CORDIC mode controller and consumes its tagged 48-bit result stream (wr_en / wr_data).
- Upper 16 bits of each word carry the result tag (000a, 000b, 000c, 000d, 000e, 000f); the lower 32 bits carry the result.
- Words are buffered in a small FIFO, then serialized MSB-first as bytes behind a sync byte onto a valid/ready byte stream toward the host link (UART or USB bridge).
- The controller has no backpressure input, so overflow is detected and counted here, never stalled.

Parameters:
- DEPTH, 8: FIFO depth in 48-bit words; must be a power of 2 and at least 2.
- SYNC_BYTE, 8'hA5: frame-start byte emitted before every word.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- wr_en  in  1  result word strobe from the mode controller; one word per high cycle.
- wr_data  in  48  tagged result word {tag[15:0], data[31:0]}.
- o_byte  out  8  serialized byte, registered.
- o_valid  out  1  o_byte is valid, registered.
- i_ready  in  1  sink accepts o_byte this cycle.
- clr_ovf  in  1  synchronous clear of overflow and drop_count.
- overflow  out  1  sticky flag: at least one word was dropped.
- drop_count  out  16  number of dropped words, saturating at 16'hFFFF.
- occupancy  out  $clog2(DEPTH)+1  current FIFO word count.

Behaviour:
- Reset (asynchronous, active-high):
  - Clears FIFO pointers and count, state, shift register and byte index.
  - Outputs: o_valid=0, o_byte=0, overflow=0, drop_count=0, occupancy=0.
  - Reset mid-frame abandons the partial frame; no byte is re-emitted after release.
- Handshake: a byte transfers on a cycle where o_valid && i_ready. While o_valid=1 and i_ready=0, o_byte is held stable. o_valid never drops before transfer.
- FIFO:
  - pop = serializer loads the head word this cycle.
  - Write is accepted when wr_en && (count<DEPTH || pop). Write into a full FIFO with a simultaneous pop succeeds.
  - Otherwise wr_en while full drops the word: overflow<=1, and drop_count increments unless already saturated.
  - count updates by +1, -1 or 0 for write-only, pop-only, or both.
  - Pointers wrap modulo DEPTH.
  - occupancy equals count.
- State machine:
  - S_IDLE: o_valid=0. If count!=0: pop, shreg<=head word, o_byte<=SYNC_BYTE, o_valid<=1, go to S_SYNC.
  - S_SYNC: on transfer, o_byte<=shreg[47:40], idx<=0, go to S_DATA.
  - S_DATA:
    - On transfer with idx<5: shift shreg left 8, o_byte<=next byte, idx++.
    - On transfer with idx==5 and count!=0: pop the next word, o_byte<=SYNC_BYTE, stay valid, go to S_SYNC (no bubble).
    - On transfer with idx==5 and count==0: o_valid<=0, go to S_IDLE.
- Frame format: 7 bytes in order SYNC, tag[15:8], tag[7:0], data[31:24], data[23:16], data[15:8], data[7:0].
- Latency: wr_en at cycle N into an empty idle block gives o_valid=1 with SYNC at cycle N+2. With i_ready held at 1, the last byte of that frame transfers at N+8.
- Throughput: with i_ready constantly 1 and the FIFO non-empty, one byte per cycle; back-to-back frames have no idle cycle.
- clr_ovf:
  - Clears overflow and drop_count next cycle.
  - If a drop occurs in the same cycle, the drop wins: overflow=1, drop_count=1.
- wr_data is sampled only when a write is accepted. Dropped word contents are discarded.

Test Plan:
- Single word: reset, i_ready=1, one wr_en with 48'h000a_3F80_0000 at N.
  - Required: o_valid rises at N+2.
  - Bytes A5,00,0A,3F,80,00,00 on consecutive cycles, then o_valid=0.
- Back-to-back: two words (000c_12345678, 000b_DEADBEEF) on consecutive cycles, i_ready=1.
  - Required: 14 bytes in 14 consecutive cycles, second SYNC immediately after byte 0x78, occupancy peaks at 1.
- Backpressure: one word, i_ready toggling 1,0,0,1.
  - Required: o_byte stable while i_ready=0, no byte duplicated or skipped, 7 transfers total.
- Overflow: i_ready=0, DEPTH+1+2 = 11 writes.
  - Required: the first is loaded into the serializer and the next 8 fill the FIFO (occupancy=8), so the last 2 are dropped; overflow=1, drop_count=2.
  - After i_ready=1, exactly 9 frames are emitted, all in write order.
- Full with pop: FIFO full, wr_en coincides with the pop at a frame boundary.
  - Required: no drop, drop_count unchanged, occupancy stays 8.
- Reset mid-frame: assert reset after the 3rd byte of a frame with 2 words queued.
  - Required: o_valid=0 immediately, occupancy=0, and no output after reset release until a new write.

Source files
------------

// File: rtl/cordic_result_serializer.sv
// CORDIC result serializer: buffers tagged 48-bit results in a small FIFO and
// streams each one as a 7-byte frame (sync byte, then the word MSB-first) on a
// valid/ready byte interface. The upstream controller cannot be stalled, so a
// write into a full FIFO is dropped and counted instead.
module cordic_result_serializer #(
  parameter int          DEPTH     = 8,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [47:0]              wr_data,
  output logic [7:0]               o_byte,
  output logic                     o_valid,
  input  logic                     i_ready,
  input  logic                     clr_ovf,
  output logic                     overflow,
  output logic [15:0]              drop_count,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [2:0]    LAST_IDX = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_DATA} state_t;

  state_t        state, state_n;
  logic [47:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [47:0]   shreg, shreg_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    byte_n;
  logic          valid_n;
  logic          xfer, pop, has_data, wr_ok, drop;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign xfer      = o_valid && i_ready;
  assign has_data  = (count != '0);
  // A full FIFO can still take a word in the same cycle its head is popped.
  assign wr_ok     = wr_en && ((count < CNT_FULL) || pop);
  assign drop      = wr_en && !wr_ok;
  assign occupancy = count;

  // Word storage; contents need no reset since pointers/count qualify them.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  // FIFO pointers and word count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_ok, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow flag and saturating drop counter; a drop beats a clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow   <= 1'b1;
      drop_count <= clr_ovf ? 16'd1 : sat_inc16(drop_count);
    end else if (clr_ovf) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end
  end

  // Serializer state, shift register and registered byte outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      shreg   <= '0;
      idx     <= '0;
      o_byte  <= '0;
      o_valid <= 1'b0;
    end else begin
      state   <= state_n;
      shreg   <= shreg_n;
      idx     <= idx_n;
      o_byte  <= byte_n;
      o_valid <= valid_n;
    end
  end

  // Next-state logic: frames follow each other without a bubble when queued.
  always_comb begin
    state_n = state;
    shreg_n = shreg;
    idx_n   = idx;
    byte_n  = o_byte;
    valid_n = o_valid;
    pop     = 1'b0;
    case (state)
      S_IDLE: begin
        valid_n = 1'b0;
        if (has_data) begin
          pop     = 1'b1;
          shreg_n = mem[rd_ptr];
          byte_n  = SYNC_BYTE;
          valid_n = 1'b1;
          state_n = S_SYNC;
        end
      end
      S_SYNC: begin
        if (xfer) begin
          byte_n  = shreg[47:40];
          idx_n   = 3'd0;
          state_n = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer) begin
          if (idx != LAST_IDX) begin
            shreg_n = {shreg[39:0], 8'h00};
            byte_n  = shreg[39:32];
            idx_n   = idx + 3'd1;
          end else if (has_data) begin
            pop     = 1'b1;
            shreg_n = mem[rd_ptr];
            byte_n  = SYNC_BYTE;
            state_n = S_SYNC;
          end else begin
            valid_n = 1'b0;
            state_n = S_IDLE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule
